// File: rtl/apply_sweep_scheduler.sv
// apply_sweep_scheduler: sweeps the partition's node-state memory once per
// accepted start and streams each record into apply. A 2-entry skid FIFO
// decouples memory read latency from apply back-pressure. A barrier token
// carrying the round number closes each sweep.
module apply_sweep_scheduler #(
    parameter int          NUM_NODES    = 16,
    parameter int          ADDR_W       = 4,
    parameter logic [31:0] NODEID_BASE  = 32'h0,
    parameter bit          SKIP_INVALID = 1'b1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start_valid,
    input  logic [1:0]        start_round,
    output logic              start_ack,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_adr,
    input  logic [33:0]       mem_rd_data,
    output logic              valid_out,
    output logic [31:0]       nodeid_out,
    output logic [31:0]       state_parent_out,
    output logic              state_active_out,
    output logic              state_valid_out,
    output logic [1:0]        round_out,
    output logic              barrier_out,
    input  logic              apply_ready,
    output logic              busy,
    output logic              done,
    output logic              round_err
);

    localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(NUM_NODES - 1);

    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_BARRIER} state_t;

    typedef struct packed {
        logic [31:0] nodeid;
        logic [31:0] parent;
        logic        active;
        logic        valid;
    } rec_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] rd_adr;       // next address to issue
    logic [ADDR_W-1:0] rd_adr_q;     // address of the read in flight
    logic              rd_inflight;  // read issued last cycle, data returns now
    logic              rd_issue;
    logic              last_issue;
    logic              accept;

    rec_t              fifo_mem [2];
    logic              wr_ptr, rd_ptr;
    logic [1:0]        fifo_cnt;
    logic              fifo_empty;
    logic              push, pop;
    logic [2:0]        occupancy;
    rec_t              push_rec, head;

    logic [1:0]        round_q, exp_round;
    logic              err_q, done_q;

    // Flow control: count FIFO slots already claimed by stored and in-flight
    // records, crediting this cycle's pop so a full-rate stream never bubbles.
    always_comb begin
        fifo_empty = (fifo_cnt == 2'd0);
        pop        = !fifo_empty && apply_ready;
        push       = rd_inflight && (!SKIP_INVALID || mem_rd_data[33]);
        occupancy  = {1'b0, fifo_cnt} + {2'b00, rd_inflight} - {2'b00, pop};
        accept     = start_valid && (state == S_IDLE);
        rd_issue   = (state == S_SWEEP) && (occupancy < 3'd2);
        last_issue = rd_issue && (rd_adr == LAST_ADR);
        push_rec   = {NODEID_BASE + 32'(rd_adr_q), mem_rd_data[31:0],
                      mem_rd_data[32], mem_rd_data[33]};
        head       = fifo_empty ? '0 : fifo_mem[rd_ptr];
    end

    // Next-state logic for the sweep sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (accept)                       state_nxt = S_SWEEP;
            S_SWEEP:   if (last_issue)                   state_nxt = S_DRAIN;
            S_DRAIN:   if (fifo_empty && !rd_inflight)   state_nxt = S_BARRIER;
            S_BARRIER: if (apply_ready)                  state_nxt = S_IDLE;
            default:                                     state_nxt = S_IDLE;
        endcase
    end

    // Sequencer state, read address generation and round bookkeeping.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= S_IDLE;
            rd_adr      <= '0;
            rd_adr_q    <= '0;
            rd_inflight <= 1'b0;
            round_q     <= 2'd0;
            exp_round   <= 2'd0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            rd_inflight <= rd_issue;
            done_q      <= (state == S_BARRIER) && apply_ready;
            if (rd_issue) begin
                rd_adr_q <= rd_adr;
                rd_adr   <= rd_adr + ADDR_W'(1);
            end
            if (accept) begin
                round_q   <= start_round;
                rd_adr    <= '0;
                exp_round <= start_round + 2'd1;
                if (start_round != exp_round) err_q <= 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy; push and pop may happen together.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // FIFO storage; contents are don't-care while the count says empty.
    always_ff @(posedge sys_clk) begin
        if (push) fifo_mem[wr_ptr] <= push_rec;
    end

    // Head of FIFO (zeroed when empty) drives the stream; barrier adds the flag.
    always_comb begin
        start_ack        = (state == S_IDLE);
        busy             = (state != S_IDLE);
        mem_rd_en        = rd_issue;
        mem_rd_adr       = rd_adr;
        valid_out        = !fifo_empty || (state == S_BARRIER);
        barrier_out      = (state == S_BARRIER);
        nodeid_out       = head.nodeid;
        state_parent_out = head.parent;
        state_active_out = head.active;
        state_valid_out  = head.valid;
        round_out        = round_q;
        done             = done_q;
        round_err        = err_q;
    end

endmodule

// File: tb/tb_apply_sweep_scheduler.sv
// Scoreboard bench: instance 0 skips invalid records (base 0), instance 1
// streams everything (base 0x100). Expected records are queued when a start
// is accepted; a negedge monitor pops and compares on each transfer.
module tb_apply_sweep_scheduler;

    localparam int N  = 4;
    localparam int AW = 4;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        start_valid = 1'b0;
    logic [1:0]  start_round = 2'd0;
    logic        apply_ready = 1'b1;
    logic        toggle_en = 1'b0;

    logic        start_ack   [2];
    logic        mem_rd_en   [2];
    logic [AW-1:0] mem_rd_adr [2];
    logic [33:0] mem_rd_data [2];
    logic        valid_out   [2];
    logic [31:0] nodeid_out  [2];
    logic [31:0] parent_out  [2];
    logic        active_out  [2];
    logic        svalid_out  [2];
    logic [1:0]  round_out   [2];
    logic        barrier_out [2];
    logic        busy        [2];
    logic        done        [2];
    logic        round_err   [2];

    always #5 sys_clk = ~sys_clk;

    apply_sweep_scheduler #(.NUM_NODES(N), .ADDR_W(AW), .NODEID_BASE(32'h0),
                            .SKIP_INVALID(1'b1)) dut_a (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .start_valid(start_valid), .start_round(start_round), .start_ack(start_ack[0]),
        .mem_rd_en(mem_rd_en[0]), .mem_rd_adr(mem_rd_adr[0]), .mem_rd_data(mem_rd_data[0]),
        .valid_out(valid_out[0]), .nodeid_out(nodeid_out[0]),
        .state_parent_out(parent_out[0]), .state_active_out(active_out[0]),
        .state_valid_out(svalid_out[0]), .round_out(round_out[0]),
        .barrier_out(barrier_out[0]), .apply_ready(apply_ready),
        .busy(busy[0]), .done(done[0]), .round_err(round_err[0]));

    apply_sweep_scheduler #(.NUM_NODES(N), .ADDR_W(AW), .NODEID_BASE(32'h100),
                            .SKIP_INVALID(1'b0)) dut_b (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .start_valid(start_valid), .start_round(start_round), .start_ack(start_ack[1]),
        .mem_rd_en(mem_rd_en[1]), .mem_rd_adr(mem_rd_adr[1]), .mem_rd_data(mem_rd_data[1]),
        .valid_out(valid_out[1]), .nodeid_out(nodeid_out[1]),
        .state_parent_out(parent_out[1]), .state_active_out(active_out[1]),
        .state_valid_out(svalid_out[1]), .round_out(round_out[1]),
        .barrier_out(barrier_out[1]), .apply_ready(apply_ready),
        .busy(busy[1]), .done(done[1]), .round_err(round_err[1]));

    // Node-state memory model: 1-cycle read latency, junk when not read.
    logic [33:0] mem [N];
    always @(posedge sys_clk) begin
        mem_rd_data[0] <= mem_rd_en[0] ? mem[mem_rd_adr[0][1:0]] : {2'($urandom), 32'($urandom)};
        mem_rd_data[1] <= mem_rd_en[1] ? mem[mem_rd_adr[1][1:0]] : {2'($urandom), 32'($urandom)};
    end

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    typedef struct packed {
        logic [31:0] id;
        logic [31:0] par;
        logic        act;
        logic        val;
        logic        bar;
        logic [1:0]  rnd;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    function automatic void q_push(int k, exp_t x);
        if (k == 0) q0.push_back(x); else q1.push_back(x);
    endfunction

    function automatic int q_size(int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t q_front(int k);
        return (k == 0) ? q0[0] : q1[0];
    endfunction

    function automatic void q_pop(int k);
        exp_t d;
        if (k == 0) d = q0.pop_front(); else d = q1.pop_front();
    endfunction

    logic [1:0] exp_r      [2];
    logic       err_m      [2];
    logic       pend_done  [2];
    logic       first_pend [2];
    int         acc_cyc    [2];
    exp_t       e_mon, got_mon, x_mon;

    // Monitor: model accepts, check stream transfers, done pulse and round_err.
    always @(negedge sys_clk) begin
        for (int k = 0; k < 2; k++) begin
            if (sys_rst) begin
                if (k == 0) q0.delete(); else q1.delete();
                exp_r[k] = 2'd0; err_m[k] = 1'b0;
                pend_done[k] = 1'b0; first_pend[k] = 1'b0;
            end else begin
                if (done[k] || pend_done[k]) begin
                    chk($sformatf("done[%0d]", k), done[k], pend_done[k]);
                    if (pend_done[k])
                        chk($sformatf("idle_at_done[%0d]", k),
                            {busy[k], start_ack[k], round_err[k]}, {1'b0, 1'b1, err_m[k]});
                    pend_done[k] = 1'b0;
                end
                if (start_valid && busy[k])
                    chk($sformatf("ack_while_busy[%0d]", k), start_ack[k], 1'b0);
                if (start_valid && start_ack[k]) begin
                    chk($sformatf("round_err_at_accept[%0d]", k), round_err[k], err_m[k]);
                    err_m[k] = err_m[k] | (start_round != exp_r[k]);
                    exp_r[k] = start_round + 2'd1;
                    for (int a = 0; a < N; a++) begin
                        if (k == 1 || mem[a][33]) begin
                            x_mon.id  = ((k == 1) ? 32'h100 : 32'h0) + 32'(a);
                            x_mon.par = mem[a][31:0];
                            x_mon.act = mem[a][32];
                            x_mon.val = mem[a][33];
                            x_mon.bar = 1'b0;
                            x_mon.rnd = start_round;
                            q_push(k, x_mon);
                        end
                    end
                    x_mon = '0;
                    x_mon.bar = 1'b1;
                    x_mon.rnd = start_round;
                    q_push(k, x_mon);
                    acc_cyc[k] = cyc;
                    first_pend[k] = 1'b1;
                end
                if (valid_out[k]) begin
                    if (q_size(k) == 0) begin
                        chk($sformatf("unexpected_out[%0d]", k), valid_out[k], 1'b0);
                    end else begin
                        e_mon = q_front(k);
                        got_mon = {nodeid_out[k], parent_out[k], active_out[k],
                                   svalid_out[k], barrier_out[k], round_out[k]};
                        chk($sformatf("stream[%0d]", k), got_mon, e_mon);
                        if (first_pend[k]) begin
                            if (!e_mon.bar && e_mon.id == ((k == 1) ? 32'h100 : 32'h0))
                                chk($sformatf("first_latency[%0d]", k), cyc - acc_cyc[k], 3);
                            first_pend[k] = 1'b0;
                        end
                        if (apply_ready) begin
                            q_pop(k);
                            if (e_mon.bar) pend_done[k] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // apply_ready driver: steady 1, or alternating when toggle_en is set.
    initial begin
        forever begin
            @(posedge sys_clk);
            #1;
            if (toggle_en) apply_ready = ~apply_ready;
            else           apply_ready = 1'b1;
        end
    end

    task automatic init_mem();
        mem[0] = {2'b11, 32'h0000_00AA};
        mem[1] = {2'b10, 32'h1234_5678};
        mem[2] = {2'b11, 32'hDEAD_BEEF};
        mem[3] = {2'b10, 32'h0000_0003};
    endtask

    task automatic do_reset();
        @(posedge sys_clk);
        #1 sys_rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++)
            chk($sformatf("reset_state[%0d]", k),
                {valid_out[k], busy[k], start_ack[k], done[k], round_err[k], mem_rd_en[k],
                 barrier_out[k], round_out[k], nodeid_out[k], parent_out[k]},
                {6'b001000, 67'b0});
        repeat (2) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
    endtask

    task automatic do_start(input logic [1:0] r);
        @(posedge sys_clk);
        #1 start_valid = 1'b1;
        start_round = r;
        @(posedge sys_clk);
        #1 start_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge sys_clk);
            if (!busy[0] && !busy[1]) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL wait_idle: still busy after 300 cycles");
        end
    endtask

    initial begin
        bit ok;
        logic [1:0] seq [5];
        seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd2; seq[3] = 2'd3; seq[4] = 2'd0;
        init_mem();
        do_reset();

        // full-rate sweep, round 0
        do_start(2'd0); wait_idle();

        // alternating back-pressure, round 1
        toggle_en = 1'b1;
        do_start(2'd1); wait_idle();
        toggle_en = 1'b0;

        // nodes 1,2 invalid, round 2
        mem[1][33] = 1'b0; mem[2][33] = 1'b0;
        do_start(2'd2); wait_idle();
        init_mem();

        // round sequencing from a fresh reset, then an out-of-order round
        do_reset();
        for (int i = 0; i < 5; i++) begin do_start(seq[i]); wait_idle(); end
        do_start(2'd2); wait_idle();
        do_start(2'd3); wait_idle();

        // start held across a sweep: round 0 accepted, round 1 waits for IDLE
        @(posedge sys_clk);
        #1 start_valid = 1'b1; start_round = 2'd0;
        @(posedge sys_clk);
        #1 start_round = 2'd1;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge sys_clk);
            if (start_ack[0] && start_ack[1]) begin ok = 1'b1; break; end
        end
        if (!ok) begin n_vec++; n_err++; $display("FAIL held_start: never re-acked"); end
        @(posedge sys_clk);
        #1 start_valid = 1'b0;
        wait_idle();

        // reset with address 2 in flight, then a clean sweep
        do_start(2'd2);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge sys_clk);
            if (mem_rd_en[0] && mem_rd_adr[0] == 4'd2) begin ok = 1'b1; break; end
        end
        if (!ok) begin n_vec++; n_err++; $display("FAIL mid_reset: address 2 never issued"); end
        do_reset();
        do_start(2'd0); wait_idle();

        repeat (3) @(negedge sys_clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
